// File: rtl/mmio_responder.sv
// Purpose: MMIO responder hosting a serial TX byte FIFO and a 64-bit microsecond RTC.
// Latency: one cycle from request acceptance to the resp_finish pulse.
// Backpressure: serial byte writes stall in IDLE while the TX FIFO is full; the TX stream drains on tx_valid & tx_ready.
module mmio_responder #(
    parameter int          FIFO_DEPTH  = 8,
    parameter int          CLK_PER_US  = 100,
    parameter logic [63:0] SERIAL_BASE = 64'h00000000a00003f8,
    parameter logic [63:0] RTC_BASE    = 64'h00000000a0000048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_data,
    input  logic [7:0]  req_mask,
    input  logic        req_we,
    input  logic        req_re,
    output logic [63:0] resp_data,
    output logic        resp_finish,
    output logic        resp_err,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [63:0] rtc_us
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] PRESC_MAX = SW'(CLK_PER_US - 1);

    typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          accept;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    logic [SW-1:0] presc;
    logic [63:0]   rtc;
    logic          tick;
    logic          rtc_wr;
    logic [63:0]   rtc_wdat;

    logic          hit_serial;
    logic          hit_rtc;
    logic          stall;
    logic [63:0]   rd_data;
    logic          rd_err;

    // Byte offset within the word is irrelevant to decode.
    logic          unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr[2:0];

    assign hit_serial = (req_addr[63:3] == SERIAL_BASE[63:3]);
    assign hit_rtc    = (req_addr[63:3] == RTC_BASE[63:3]);

    assign fifo_full  = (count == DEPTH_C);
    assign fifo_empty = (count == '0);

    // Full check uses the registered count, so a same-cycle pop only unblocks next cycle.
    assign stall  = hit_serial & req_we & req_mask[0] & fifo_full;
    assign push   = accept & hit_serial & req_we & req_mask[0];
    assign pop    = ~fifo_empty & tx_ready;
    assign rtc_wr = accept & hit_rtc & req_we;
    assign tick   = (presc == PRESC_MAX);

    assign tx_valid    = ~fifo_empty;
    assign tx_data     = fifo_empty ? 8'h00 : mem[rd_ptr];
    assign rtc_us      = rtc;
    assign resp_finish = (state == RESP);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: accept from IDLE, pulse in RESP, wait in HOLD until the initiator lets go.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if ((req_we | req_re) & ~stall) begin
                    accept    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: state_nxt = HOLD;
            HOLD: begin
                if (!req_we && !req_re) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read data mux; writes return zero, and unmapped addresses flag an error either way.
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        if (hit_serial) begin
            if (!req_we) begin
                rd_data = {48'b0, 8'(count), 6'b0, fifo_full, fifo_empty};
            end
        end else if (hit_rtc) begin
            if (!req_we) begin
                rd_data = rtc;
            end
        end else begin
            rd_err = 1'b1;
        end
    end

    // Response registers are captured on acceptance and held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else if (accept) begin
            resp_data <= rd_data;
            resp_err  <= rd_err;
        end
    end

    // FIFO storage: entries beyond the count are never observed, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= req_data[7:0];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Per-lane merge of the RTC write data with the current value.
    always_comb begin
        rtc_wdat = rtc;
        for (int i = 0; i < 8; i++) begin
            if (req_mask[i]) begin
                rtc_wdat[i*8 +: 8] = req_data[i*8 +: 8];
            end
        end
    end

    // RTC and prescaler; a write overrides the tick and restarts the microsecond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rtc   <= '0;
            presc <= '0;
        end else if (rtc_wr) begin
            rtc   <= rtc_wdat;
            presc <= '0;
        end else if (tick) begin
            rtc   <= rtc + 64'd1;
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Purpose: directed scoreboard bench for mmio_responder (serial FIFO, RTC, decode, FSM handshake).
// Latency: expects resp_finish on the first negedge after an accepting posedge.
// Backpressure: exercises the full-FIFO stall and its release by a single TX pop.
module tb_mmio_responder;

    localparam int          DEPTH = 8;
    localparam int          CPU   = 4;
    localparam logic [63:0] SER   = 64'h00000000a00003f8;
    localparam logic [63:0] RTCA  = 64'h00000000a0000048;
    localparam logic [63:0] UNMAP = 64'h00000000a0001000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] req_addr;
    logic [63:0] req_data;
    logic [7:0]  req_mask;
    logic        req_we;
    logic        req_re;
    logic [63:0] resp_data;
    logic        resp_finish;
    logic        resp_err;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [63:0] rtc_us;

    mmio_responder #(
        .FIFO_DEPTH (DEPTH),
        .CLK_PER_US (CPU),
        .SERIAL_BASE(SER),
        .RTC_BASE   (RTCA)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_mask   (req_mask),
        .req_we     (req_we),
        .req_re     (req_re),
        .resp_data  (resp_data),
        .resp_finish(resp_finish),
        .resp_err   (resp_err),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .rtc_us     (rtc_us)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        err;
        logic        chk;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  fifo_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc;
    logic [63:0] rtc_ref;
    int          rtc_ref_cyc;
    logic [63:0] ser_b = SER;
    logic [63:0] rtc_b = RTCA;

    // Edges since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rtc_now();
        return rtc_ref + 64'((cyc - rtc_ref_cyc) / CPU);
    endfunction

    // Model the request's effect and push the expected response, then drive it.
    task automatic start_req(input logic [63:0] addr, input logic [63:0] data,
                             input logic [7:0] mask, input logic we, input logic re);
        exp_t        e;
        logic        is_ser;
        logic        is_rtc;
        logic [63:0] cur;
        int          cnt;
        is_ser = (addr[63:3] == ser_b[63:3]);
        is_rtc = (addr[63:3] == rtc_b[63:3]);
        e.data = 64'h0;
        e.err  = !(is_ser || is_rtc);
        e.chk  = !we && re;
        if (is_ser && we && mask[0]) begin
            fifo_q.push_back(data[7:0]);
        end else if (is_rtc && we) begin
            cur = rtc_now();
            for (int i = 0; i < 8; i++) begin
                if (mask[i]) cur[i*8 +: 8] = data[i*8 +: 8];
            end
            rtc_ref     = cur;
            rtc_ref_cyc = cyc + 1;
        end else if (e.chk && is_ser) begin
            cnt    = fifo_q.size();
            e.data = {48'b0, 8'(cnt), 6'b0, (cnt == DEPTH), (cnt == 0)};
        end else if (e.chk && is_rtc) begin
            e.data = rtc_now();
        end
        sb.push_back(e);
        req_addr = addr;
        req_data = data;
        req_mask = mask;
        req_we   = we;
        req_re   = re;
    endtask

    // Wait for finish, compare against the scoreboard, hold the request if asked, then release.
    task automatic finish_req(input string tag, input int exp_lat, input int hold);
        exp_t e;
        int   lat;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (resp_finish) break;
        end
        check({tag, "_finish"}, 64'(resp_finish), 64'd1);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_err"}, 64'(resp_err), 64'(e.err));
            if (e.chk) check({tag, "_data"}, resp_data, e.data);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_nofinish"}, 64'(resp_finish), 64'd0);
        end
        req_we = 1'b0;
        req_re = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        tx_ready = 1'b1;
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (!tx_valid) break;
            if (fifo_q.size() == 0) check({tag, "_extra"}, 64'(tx_valid), 64'd0);
            else                    check({tag, "_byte"}, 64'(tx_data), 64'(fifo_q.pop_front()));
            @(negedge clk);
        end
        tx_ready = 1'b0;
        check({tag, "_left"}, 64'(fifo_q.size()), 64'd0);
        check({tag, "_empty"}, 64'(tx_valid), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        req_we = 1'b0;
        req_re = 1'b0;
        repeat (2) @(negedge clk);
        rst_n       = 1'b1;
        rtc_ref     = 64'h0;
        rtc_ref_cyc = 0;
        fifo_q.delete();
    endtask

    initial begin
        rst_n    = 1'b0;
        req_addr = '0;
        req_data = '0;
        req_mask = '0;
        req_we   = 1'b0;
        req_re   = 1'b0;
        tx_ready = 1'b0;
        rtc_ref     = 64'h0;
        rtc_ref_cyc = 0;
        repeat (3) @(negedge clk);
        check("rst_finish", 64'(resp_finish), 64'd0);
        check("rst_err", 64'(resp_err), 64'd0);
        check("rst_data", resp_data, 64'd0);
        check("rst_txv", 64'(tx_valid), 64'd0);
        check("rst_txd", 64'(tx_data), 64'd0);
        check("rst_rtc", rtc_us, 64'd0);
        rst_n = 1'b1;

        // RTC read right after release, then again 40 cycles later.
        start_req(RTCA, 64'h0, 8'h00, 1'b0, 1'b1);
        finish_req("rtc_rd0", 1, 0);
        for (int i = 0; i < 100 && cyc < 40; i++) @(negedge clk);
        start_req(RTCA, 64'h0, 8'h00, 1'b0, 1'b1);
        finish_req("rtc_rd40", 1, 0);
        check("rtc_us_live", rtc_us, rtc_now());

        // Single serial byte, status read, drain.
        start_req(SER, 64'h41, 8'h01, 1'b1, 1'b0);
        finish_req("ser_wr41", 1, 0);
        check("ser_txv", 64'(tx_valid), 64'd1);
        check("ser_txd", 64'(tx_data), 64'h41);
        start_req(SER, 64'h0, 8'h00, 1'b0, 1'b1);
        finish_req("ser_st1", 1, 0);
        drain("drain1");

        // Lane-0-disabled write completes without a push.
        start_req(SER, 64'h99, 8'hFE, 1'b1, 1'b0);
        finish_req("ser_nomask", 1, 0);
        check("ser_nomask_txv", 64'(tx_valid), 64'd0);

        // Fill the FIFO, then stall a ninth write until one byte drains.
        for (int i = 0; i < DEPTH; i++) begin
            start_req(SER, 64'(8'h30 + i), 8'h01, 1'b1, 1'b0);
            finish_req("fill", 1, 0);
        end
        start_req(SER, 64'h0, 8'h00, 1'b0, 1'b1);
        finish_req("ser_st_full", 1, 0);
        start_req(SER, 64'h38, 8'h01, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_nofinish", 64'(resp_finish), 64'd0);
        end
        check("stall_head", 64'(tx_data), 64'(fifo_q.pop_front()));
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        check("stall_pop_cycle", 64'(resp_finish), 64'd0);
        finish_req("stall_wr", 1, 0);
        drain("drain_full");

        // Masked RTC write from zero, request held past the finish.
        do_reset();
        start_req(RTCA, 64'h1122334455667788, 8'h0F, 1'b1, 1'b0);
        @(negedge clk);
        check("rtc_wr_val", rtc_us, 64'h0000000055667788);
        check("rtc_wr_finish", 64'(resp_finish), 64'd1);
        begin
            exp_t e;
            e = sb.pop_front();
            check("rtc_wr_err", 64'(resp_err), 64'(e.err));
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rtc_hold_nofinish", 64'(resp_finish), 64'd0);
        end
        req_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start_req(RTCA, 64'h0, 8'h00, 1'b0, 1'b1);
        finish_req("rtc_rd_after_wr", 1, 0);

        // Unmapped read: error flag, zero data, no side effects.
        start_req(UNMAP, 64'h0, 8'h00, 1'b0, 1'b1);
        finish_req("unmapped", 1, 0);
        check("unmapped_txv", 64'(tx_valid), 64'd0);
        check("unmapped_rtc", rtc_us, rtc_now());

        // Reset asserted while the responder is in RESP after accepting a write.
        start_req(SER, 64'h77, 8'h01, 1'b1, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        check("midrst_finish", 64'(resp_finish), 64'd0);
        check("midrst_txv", 64'(tx_valid), 64'd0);
        check("midrst_rtc", rtc_us, 64'd0);
        req_we = 1'b0;
        @(negedge clk);
        rst_n       = 1'b1;
        rtc_ref     = 64'h0;
        rtc_ref_cyc = 0;
        fifo_q.delete();

        // Write and read together: treated as a write.
        start_req(SER, 64'h5A, 8'h01, 1'b1, 1'b1);
        finish_req("we_re", 1, 0);
        check("we_re_txd", 64'(tx_data), 64'h5A);
        drain("drain_wr");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
